// File: rtl/row_shift_pkg.sv
// Shared constants and types for the row-window shift scheduler.
package row_shift_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int TAPS_DEF     = 11;
    localparam int CNT_W        = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_BLANK = 2'd3
    } state_e;

endpackage

// File: rtl/row_shift_mask.sv
// Thermometer mask: bits 0..fill set, all ones once fill reaches TAPS-1 or beyond.
module row_shift_mask #(
    parameter int TAPS = 11,
    parameter int FW   = 4
) (
    input  logic [FW-1:0]   fill,
    output logic [TAPS-1:0] mask
);

    // Bit k is set when tap k already holds, or is about to receive, a pixel.
    always_comb begin
        mask = '0;
        for (int k = 0; k < TAPS; k++) begin
            mask[k] = (FW'(k) <= fill);
        end
    end

endmodule

// File: rtl/row_shift_sched.sv
// Row-window shift scheduler: sequences per-tap shift enables across a video line.
// Optional short-line detection is built when ROW_SHIFT_ERR_CHK_EN is defined;
// otherwise err_short is tied low.
// Handshake: pix_valid is a one-way strobe with no back-pressure; a pixel is
// accepted whenever pix_valid=1 in FILL/RUN, or together with line_start.
// All outputs are registered and reflect the inputs sampled at the previous edge.
import row_shift_pkg::*;

module row_shift_sched #(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int TAPS     = TAPS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             line_start,
    input  logic             pix_valid,
    output logic [TAPS-1:0]  shift_en,
    output logic             window_valid,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] x_count,
    output logic             line_done,
    output logic             err_short,
    output state_e           fsm_state
);

    localparam int              FW        = $clog2(TAPS + 1);
    localparam logic [FW-1:0]   FILL_LAST = FW'(TAPS - 1);
    localparam logic [FW-1:0]   FILL_FULL = FW'(TAPS);
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] X_MAX    = '1;

    state_e             state;
    state_e             state_nxt;
    logic [FW-1:0]      fill;
    logic [FW-1:0]      fill_nxt;
    logic [FW-1:0]      fill_base;
    logic [CNT_W-1:0]   col_nxt;
    logic [CNT_W-1:0]   col_base;
    logic [CNT_W-1:0]   x_nxt;
    logic [TAPS-1:0]    shift_nxt;
    logic [TAPS-1:0]    mask;
    logic               win_nxt;
    logic               done_nxt;
    logic               in_line;
    logic               accept;

    // A line_start restarts the line, so the coincident pixel is counted from zero.
    assign in_line   = (state == ST_FILL) || (state == ST_RUN);
    assign accept    = pix_valid && (in_line || line_start);
    assign fill_base = line_start ? '0 : fill;
    assign col_base  = line_start ? '0 : col;
    assign fsm_state = state;

    row_shift_mask #(
        .TAPS (TAPS),
        .FW   (FW)
    ) u_mask (
        .fill (fill_base),
        .mask (mask)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_nxt = state;
        fill_nxt  = fill;
        col_nxt   = col;
        x_nxt     = x_count;
        shift_nxt = '0;
        win_nxt   = 1'b0;
        done_nxt  = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
            fill_nxt  = '0;
            col_nxt   = '0;
            x_nxt     = '0;
        end else begin
            if (line_start) begin
                x_nxt = '0;
            end else if (state != ST_IDLE) begin
                x_nxt = (x_count == X_MAX) ? x_count : x_count + 1'b1;
            end else begin
                x_nxt = '0;
            end
            if (line_start) begin
                state_nxt = ST_FILL;
                fill_nxt  = '0;
                col_nxt   = '0;
            end
            if (accept) begin
                shift_nxt = mask;
                win_nxt   = (fill_base >= FILL_LAST);
                fill_nxt  = (fill_base < FILL_FULL) ? fill_base + 1'b1 : fill_base;
                col_nxt   = col_base + 1'b1;
                if (col_base == COL_LAST) begin
                    state_nxt = ST_BLANK;
                    done_nxt  = 1'b1;
                end else if (fill_nxt == FILL_FULL) begin
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_FILL;
                end
            end
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            fill         <= '0;
            col          <= '0;
            x_count      <= '0;
            shift_en     <= '0;
            window_valid <= 1'b0;
            line_done    <= 1'b0;
        end else begin
            state        <= state_nxt;
            fill         <= fill_nxt;
            col          <= col_nxt;
            x_count      <= x_nxt;
            shift_en     <= shift_nxt;
            window_valid <= win_nxt;
            line_done    <= done_nxt;
        end
    end

`ifdef ROW_SHIFT_ERR_CHK_EN
    // Sticky flag for a line restarted before all of its pixels arrived.
    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            err_short <= 1'b0;
        end else if (line_start && in_line) begin
            err_short <= 1'b1;
        end
    end
`else
    assign err_short = 1'b0;
`endif

endmodule

// File: doc/row_shift_sched.md
ROW_SHIFT_SCHED -- requirements
Module: row_shift_sched

Interface
REQ-001 Parameter H_ACTIVE, default 640: accepted pixels per line.
REQ-002 Parameter TAPS, default 11: shift-register taps in the row window (tap 0 = input end).
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  scheduler run enable.
REQ-006 line_start  input  1  one-cycle pulse at start of each video line.
REQ-007 pix_valid  input  1  input pixel present this cycle.
REQ-008 shift_en  output  TAPS  per-tap shift enable, bit k drives tap k.
REQ-009 window_valid  output  1  all TAPS taps hold valid pixels of the current line.
REQ-010 col  output  13  count of pixels accepted in current line.
REQ-011 x_count  output  13  clocks since last line_start, saturating at 8191.
REQ-012 line_done  output  1  one-cycle pulse after the H_ACTIVE-th pixel is accepted.
REQ-013 err_short  output  1  sticky flag: line_start arrived before H_ACTIVE pixels accepted.

Function
REQ-014 States IDLE, FILL, RUN, BLANK; all outputs registered, one-cycle latency from sampled inputs (datapath delays pixel by one register to align).
REQ-015 "Accept" = pix_valid=1 while state is FILL or RUN; pix_valid in IDLE or BLANK is ignored, shift_en stays 0.
REQ-016 IDLE: shift_en=0, window_valid=0; line_start with enable=1 -> FILL, col=0, fill=0, x_count=0.
REQ-017 FILL: on accept with fill count f (0..TAPS-1), next-cycle shift_en = thermometer mask of bits 0..f; f increments; accept at f=TAPS-1 -> RUN.
REQ-018 RUN: on accept, next-cycle shift_en = all ones; no accept -> shift_en=0.
REQ-019 window_valid=1 the cycle after the TAPS-th accept and the cycle after every later accept in the line; otherwise 0 (630 windows per 640-pixel line).
REQ-020 col increments per accept; accept with col=H_ACTIVE-1 -> BLANK, line_done=1 next cycle, col holds H_ACTIVE.
REQ-021 BLANK: shift_en=0, window_valid=0; line_start -> FILL as REQ-016.
REQ-022 line_start in FILL or RUN (short line): abort line, restart FILL with col=0, fill=0, x_count=0; pixel accepted same cycle counts as first pixel of new line.
REQ-023 x_count resets to 0 on line_start, else increments, saturating at 8191 in any non-IDLE state; held 0 in IDLE.
REQ-024 enable=0 -> IDLE next cycle from any state; shift_en, window_valid, line_done cleared; col and x_count cleared.
REQ-025 line_start and pix_valid coincident in BLANK/IDLE: transition to FILL and accept that pixel (f=0 mask).

Reset
REQ-026 rst_n=0 at a clock edge -> IDLE; shift_en=0, window_valid=0, col=0, x_count=0, line_done=0, err_short=0; overrides all other inputs, including mid-line.

Configuration
REQ-027 Macro ROW_SHIFT_ERR_CHK_EN defined: err_short sets on REQ-022 condition, clears only on reset or enable=0.
REQ-028 Macro ROW_SHIFT_ERR_CHK_EN undefined: err_short tied 0, detection logic absent; all other behaviour identical.

Structure
REQ-029 Package row_shift_pkg holds H_ACTIVE/TAPS defaults, 13-bit counter width constant and state enum typedef.
REQ-030 One sub-module row_shift_mask: combinational thermometer mask (fill count -> TAPS-bit mask); counters and FSM stay in top level.

Verification
REQ-031 Reset then line_start, 640 back-to-back pix_valid -> shift_en 0x001,0x003,...,0x7FF over first 11 accepts; window_valid high exactly 630 cycles; line_done one pulse; col=640.
REQ-032 Gapped pix_valid (1 of every 3 cycles) -> shift_en and window_valid high only cycles following accepts; 630 windows total.
REQ-033 line_start after 300 pixels -> FILL restart, col=0, next shift_en=0x001; err_short=1 with macro, 0 without.
REQ-034 pix_valid held high 200 cycles in BLANK -> shift_en=0, col stays 640.
REQ-035 No line_start for 9000 cycles after one -> x_count saturates at 8191.
REQ-036 rst_n=0 mid-RUN (col=400) -> next cycle all outputs 0, state IDLE; enable=0 mid-FILL -> IDLE, shift_en=0.
